// File: rtl/reg_file_burst_if.sv
// Bus bundle for reg_file_burst: write/read request, burst read response,
// error strobe and the four exported configuration registers.
interface reg_file_burst_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 3
);
  logic [DATA_WIDTH-1:0] WrData;
  logic [ADDR_WIDTH-1:0] Address;
  logic                  WrEn;
  logic                  RdEn;
  logic [LEN_WIDTH-1:0]  RdLen;
  logic [DATA_WIDTH-1:0] RdData;
  logic                  RdData_Valid;
  logic                  Busy;
  logic                  Err;
  logic [DATA_WIDTH-1:0] REG0, REG1, REG2, REG3;

  modport master (
    output WrData, Address, WrEn, RdEn, RdLen,
    input  RdData, RdData_Valid, Busy, Err, REG0, REG1, REG2, REG3
  );
  modport slave (
    input  WrData, Address, WrEn, RdEn, RdLen,
    output RdData, RdData_Valid, Busy, Err, REG0, REG1, REG2, REG3
  );
endinterface

// File: rtl/reg_file_burst.sv
// Parametrised register bank with burst reads (one beat per cycle),
// read-only protection, Err strobe on illegal requests and live REG0..REG3.
module reg_file_burst #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 16,
  parameter int                    LEN_WIDTH  = 3,
  parameter logic [DEPTH-1:0]      RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RST_REG2   = 8'h81,
  parameter logic [DATA_WIDTH-1:0] RST_REG3   = 8'd32
) (
  input  logic          CLK,
  input  logic          RST,
  reg_file_burst_if.slave bus
);
  localparam int                  NADDR   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH-1);
  // RO mask padded to the full address space so any Address can index it
  localparam logic [NADDR-1:0]    RO_EXT  = NADDR'(RO_MASK);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  vld_q, err_q;

  logic                  idle, in_rng, wr_req, rd_req, wr_ok, rd_ok, err_d;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_word;

  function automatic logic [ADDR_WIDTH-1:0] inc(input logic [ADDR_WIDTH-1:0] a);
    return (a == LAST) ? '0 : a + 1'b1;
  endfunction

  assign idle   = (state_q == IDLE);
  assign in_rng = ({1'b0, bus.Address} < DEPTH_W);
  assign wr_req = idle & bus.WrEn & ~bus.RdEn;
  assign rd_req = idle & bus.RdEn & ~bus.WrEn;
  assign wr_ok  = wr_req & in_rng & ~RO_EXT[bus.Address];
  assign rd_ok  = rd_req & in_rng;
  assign err_d  = idle & ((bus.WrEn & bus.RdEn)
                        | ((bus.WrEn ^ bus.RdEn) & ~in_rng)
                        | (wr_req & in_rng & RO_EXT[bus.Address]));
  assign rd_addr = idle ? bus.Address : ptr_q;

  // Explicit mux keeps out-of-range addresses from indexing the array
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++)
      if (rd_addr == ADDR_WIDTH'(i)) rd_word = regs_q[i];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      rd_q    <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        regs_q[i] <= (i == 2) ? RST_REG2 : (i == 3) ? RST_REG3 : '0;
    end else begin
      vld_q <= 1'b0;
      err_q <= err_d;
      case (state_q)
        IDLE: begin
          for (int i = 0; i < DEPTH; i++)
            if (wr_ok && bus.Address == ADDR_WIDTH'(i)) regs_q[i] <= bus.WrData;
          if (rd_ok) begin
            rd_q  <= rd_word;
            vld_q <= 1'b1;
            ptr_q <= inc(bus.Address);
            rem_q <= bus.RdLen;
            if (bus.RdLen != '0) state_q <= BURST;
          end
        end
        BURST: begin
          // rem_q counts beats still to issue; leaving on the last one drops
          // Busy in the cycle that presents it
          rd_q  <= rd_word;
          vld_q <= 1'b1;
          ptr_q <= inc(ptr_q);
          rem_q <= rem_q - 1'b1;
          if (rem_q == LEN_WIDTH'(1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.RdData       = rd_q;
  assign bus.RdData_Valid = vld_q;
  assign bus.Busy         = (state_q == BURST);
  assign bus.Err          = err_q;
  assign bus.REG0         = regs_q[0];
  assign bus.REG1         = regs_q[1];
  assign bus.REG2         = regs_q[2];
  assign bus.REG3         = regs_q[3];
endmodule

// File: doc/reg_file_burst.md
# reg_file_burst

Parametrised configuration register file with burst read, read-only protection and error reporting, used as the central register bank between the system controller and the ALU, UART and clock divider. It generalises the fixed 16×8 register file: depth, width and reset values are parameters; a single request can read up to 2^LEN_WIDTH consecutive registers, one per cycle. Illegal accesses are rejected and flagged. The four reserved registers are exported continuously.

## Interface
Parameters:
- ADDR_WIDTH, 4, address bus width
- DATA_WIDTH, 8, register and data bus width
- DEPTH, 16, number of implemented registers (4 ≤ DEPTH ≤ 2^ADDR_WIDTH)
- LEN_WIDTH, 3, burst length field width
- RO_MASK, 0 (DEPTH bits), bit i = 1 makes register i read-only to the bus
- RST_REG2, 8'h81, reset value of register 2 (UART config: parity enable, even parity, prescale 32)
- RST_REG3, 8'd32, reset value of register 3 (clock divider ratio)

Ports:
- CLK  in  1  clock; one clock domain, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- WrData  in  DATA_WIDTH  write data
- Address  in  ADDR_WIDTH  write address / burst start address
- WrEn  in  1  write request
- RdEn  in  1  read request
- RdLen  in  LEN_WIDTH  burst length minus one (0 = single read)
- RdData  out  DATA_WIDTH  read data, registered
- RdData_Valid  out  1  one-cycle strobe per read beat
- Busy  out  1  high while further burst beats are pending; requests ignored
- Err  out  1  one-cycle strobe on a rejected request
- REG0..REG3  out  DATA_WIDTH each  live contents of registers 0..3

## Operation
- Reset (RST=1 at an edge): all registers 0 except reg2=RST_REG2, reg3=RST_REG3; RdData=0, RdData_Valid=0, Busy=0, Err=0; burst counter and address pointer cleared. Reset mid-burst aborts the burst with no further beats.
- States: IDLE, BURST. Requests are sampled only when Busy=0 (IDLE, or the BURST cycle presenting the last beat).
- Write accepted when WrEn=1, RdEn=0, Address<DEPTH, RO_MASK[Address]=0: register updated at that edge.
- Read accepted when RdEn=1, WrEn=0, Address<DEPTH: beat k (k=0..RdLen) returns register (Address+k) mod DEPTH. RdLen=0 stays in IDLE; RdLen>0 enters BURST and returns to IDLE after the last beat.
- Rejected, with Err pulsed and no state change: WrEn&RdEn together; Address≥DEPTH on either request; a write to a read-only register.
- WrEn/RdEn asserted while Busy=1: ignored silently, no Err, no effect.
- Burst wrap: address pointer wraps from DEPTH-1 to 0, including when DEPTH < 2^ADDR_WIDTH.
- RdData holds its last value when RdData_Valid=0.
- REG0..REG3 reflect register contents combinationally from the array, so they update the cycle after an accepted write.

## Timing
- Request sampled at edge N. Write: data visible on REGx and to reads sampled at N+1 or later.
- Read: beat k is on RdData with RdData_Valid=1 during cycle N+1+k; RdLen+1 consecutive valid cycles, no gaps.
- Busy=1 for cycles N+1..N+RdLen, where N+RdLen is the cycle before the last beat. Busy=0 in the last-beat cycle, so a new request there gives back-to-back bursts with no bubble.
- Err asserts in cycle N+1 for exactly one cycle. RdData_Valid and Err are never both 1 for the same request.
- Throughput: one access per cycle; single reads and writes have no back-pressure.

## Test plan
- Reset then read addresses 0..3 singly -> RdData 0x00, 0x00, 0x81, 0x20 at N+1, each with a 1-cycle valid; REG2=0x81, REG3=0x20.
- Write 0xA5 to addr 5, then read addr 5 the next cycle -> RdData=0xA5 valid one cycle after the read; Err stays 0.
- Fill regs 14,15,0,1 with 0x11..0x44, then burst read Address=14, RdLen=3 -> beats 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles; Busy high for the first 3; a WrEn during Busy has no effect.
- RO_MASK bit 3 set: write 0x07 to addr 3 -> Err pulse at N+1, REG3 stays 0x20. WrEn&RdEn together -> Err pulse, no valid.
- DEPTH=12: read addr 13 -> Err pulse, no valid. Burst from 10 with RdLen=2 -> addresses 10, 11, 0.
- RST asserted during the 2nd beat of a 4-beat burst -> next cycle RdData_Valid=0, Busy=0, RdData=0, and no further beats.
